// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher
//   Framed multi-word XOR stream cipher. Every accepted data word is XORed with
//   one key word; the key index advances round-robin over KEY_WORDS words.
//   Encrypt and decrypt are the same operation.
//
//   Optional build macro: KEYSTREAM_ROTATE_EN
//     defined   : a working copy of the key is reloaded from the stored key on
//                 every accepted start and each word rotates left by one bit
//                 whenever the key index wraps.
//     undefined : the stored key is used directly (period KEY_WORDS).
//
// Ports
//   iClk, iRst           clock (rising) / async active-low reset
//   iEn                  global enable; 0 freezes every register
//   iKey_Load, iKey      key capture (IDLE only), word k = iKey[k*DATA_W +: DATA_W]
//   iStart, iLen         frame start and length in words (IDLE only)
//   iData_Valid, iData   input stream, oData_Ready is its ready
//   oData_Valid, oData   output stream, iOut_Ready is its ready
//   oBusy                state != IDLE
//   oDone                one-cycle pulse at frame completion
//   oKey_Err             sticky: start attempted with no key loaded
module xor_stream_cipher #(
  parameter int DATA_W    = 8,
  parameter int KEY_WORDS = 4,
  parameter int LEN_W     = 8
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iEn,
  input  logic                        iKey_Load,
  input  logic [DATA_W*KEY_WORDS-1:0] iKey,
  input  logic                        iStart,
  input  logic [LEN_W-1:0]            iLen,
  input  logic                        iData_Valid,
  input  logic [DATA_W-1:0]           iData,
  output logic                        oData_Ready,
  output logic                        oData_Valid,
  output logic [DATA_W-1:0]           oData,
  input  logic                        iOut_Ready,
  output logic                        oBusy,
  output logic                        oDone,
  output logic                        oKey_Err
);

  localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                              state, stateNxt;
  logic [KEY_WORDS-1:0][DATA_W-1:0]    keyIn, keyReg, keyUse;
  logic                                keyValid, keyErr;
  logic [IDX_W-1:0]                    idx;
  logic [LEN_W-1:0]                    count, len;
  logic                                keyLd, startReq, startOk;
  logic                                inXfer, outXfer, idxWrap, lastWord;

  assign keyIn    = iKey;
  assign keyLd    = iEn && (state == IDLE) && iKey_Load;
  assign startReq = iEn && (state == IDLE) && iStart;
  // A key loaded in the same cycle counts, so the start uses the new key.
  assign startOk  = startReq && (keyValid || iKey_Load);

  assign oData_Ready = iEn && (state == RUN) && (!oData_Valid || iOut_Ready);
  assign inXfer      = iData_Valid && oData_Ready;
  assign outXfer     = iEn && oData_Valid && iOut_Ready;
  assign idxWrap     = (idx == IDX_W'(KEY_WORDS - 1));
  assign lastWord    = (count == len - LEN_W'(1));

  // Stored key
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)      keyReg <= '0;
    else if (keyLd) keyReg <= keyIn;
  end

`ifdef KEYSTREAM_ROTATE_EN
  logic [KEY_WORDS-1:0][DATA_W-1:0] keyWork, keyRot;

  for (genvar g = 0; g < KEY_WORDS; g++) begin : gRot
    assign keyRot[g] = {keyWork[g][DATA_W-2:0], keyWork[g][DATA_W-1]};
  end

  // Working key restarts from the stored (or just-loaded) key every frame.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)                    keyWork <= '0;
    else if (startOk)             keyWork <= iKey_Load ? keyIn : keyReg;
    else if (inXfer && idxWrap)   keyWork <= keyRot;
  end

  assign keyUse = keyWork;
`else
  assign keyUse = keyReg;
`endif

  // FSM: state register
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= IDLE;
    else       state <= stateNxt;
  end

  // FSM: next state
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:  if (startOk) stateNxt = (iLen == '0) ? DONE : RUN;
      RUN:   if (inXfer && lastWord) stateNxt = DRAIN;
      DRAIN: if (iEn && (!oData_Valid || iOut_Ready)) stateNxt = DONE;
      DONE:  if (iEn) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    oBusy = (state != IDLE);
    oDone = iEn && (state == DONE);
  end

  // Datapath, key status and frame counters
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      keyValid    <= 1'b0;
      keyErr      <= 1'b0;
      idx         <= '0;
      count       <= '0;
      len         <= '0;
      oData       <= '0;
      oData_Valid <= 1'b0;
    end else begin
      if (keyLd) begin
        keyValid <= 1'b1;
        keyErr   <= 1'b0;
      end
      if (startReq && !startOk) keyErr <= 1'b1;
      if (startOk) begin
        len   <= iLen;
        count <= '0;
        idx   <= '0;
      end
      if (inXfer) begin
        oData       <= iData ^ keyUse[idx];
        oData_Valid <= 1'b1;
        idx         <= idxWrap ? '0 : idx + IDX_W'(1);
        count       <= count + LEN_W'(1);
      end else if (outXfer) begin
        oData_Valid <= 1'b0;
      end
    end
  end

  assign oKey_Err = keyErr;

endmodule

// File: tb/tb_xor_stream_cipher.sv
module tb_xor_stream_cipher;
  localparam int DW = 8, KW = 4, LW = 8;

  logic          iClk = 1'b0, iRst = 1'b0, iEn = 1'b0;
  logic          iKey_Load = 1'b0, iStart = 1'b0, iData_Valid = 1'b0;
  logic          iOut_Ready;
  logic [DW*KW-1:0] iKey = '0;
  logic [LW-1:0] iLen = '0;
  logic [DW-1:0] iData = '0;
  logic          oData_Ready, oData_Valid, oBusy, oDone, oKey_Err;
  logic [DW-1:0] oData;

  xor_stream_cipher #(.DATA_W(DW), .KEY_WORDS(KW), .LEN_W(LW)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iKey_Load(iKey_Load), .iKey(iKey),
    .iStart(iStart), .iLen(iLen), .iData_Valid(iData_Valid), .iData(iData),
    .oData_Ready(oData_Ready), .oData_Valid(oData_Valid), .oData(oData),
    .iOut_Ready(iOut_Ready), .oBusy(oBusy), .oDone(oDone), .oKey_Err(oKey_Err)
  );

  always #5 iClk = ~iClk;

  int nChecks = 0, nErrs = 0;
  int cyc = 0, doneCnt = 0, doneCyc = 0, lastOutCyc = 0, stallCnt = 0;
  logic [7:0] outQ[$];
  bit   bpMode = 1'b0;
  int   bpPhase = 0;
  logic [3:0] bpPat = 4'b1001;
  logic stallPrev = 1'b0;
  logic [7:0] stallData = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ready: constant 1, or the 1,0,0,1 backpressure pattern.
  always @(negedge iClk) begin
    iOut_Ready = bpMode ? bpPat[bpPhase % 4] : 1'b1;
    bpPhase++;
  end

  // Output collector and stall monitor (values sampled before the edge updates).
  always @(posedge iClk) begin
    cyc++;
    if (oDone) begin doneCnt++; doneCyc = cyc; end
    if (iEn && oData_Valid && iOut_Ready) begin
      outQ.push_back(oData);
      lastOutCyc = cyc;
    end
    if (stallPrev) begin
      chk("hold_data", oData, stallData);
      chk("hold_vld", oData_Valid, 1);
    end
    stallPrev = iEn && oData_Valid && !iOut_Ready;
    if (stallPrev) begin
      stallCnt++;
      stallData = oData;
      chk("stall_rdy", oData_Ready, 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge iClk); #1; end
  endtask

  task automatic startFrame(input logic [7:0] n);
    iLen = n; iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] w);
    int t = 0;
    iData_Valid = 1'b1; iData = w;
    do begin @(negedge iClk); #1; t++; end while (!oData_Ready && t < 40);
    if (!oData_Ready) chk("send_timeout", oData_Ready, 1);
    @(posedge iClk); #1;
    iData_Valid = 1'b0;
  endtask

  task automatic waitDone(input int n0);
    int t = 0;
    while (doneCnt == n0 && t < 40) begin tick(); t++; end
    chk("done_seen", doneCnt, n0 + 1);
  endtask

  task automatic runFrame(input string tag, input logic [7:0] din[6],
                          input logic [7:0] exp[6], input int n);
    int d0 = doneCnt;
    outQ.delete();
    startFrame(8'(n));
    for (int i = 0; i < n; i++) sendWord(din[i]);
    waitDone(d0);
    tick();
    chk({tag, "_n"}, outQ.size(), n);
    for (int i = 0; i < n; i++)
      if (i < outQ.size()) chk(tag, outQ[i], exp[i]);
    chk({tag, "_busy"}, oBusy, 0);
  endtask

  logic [7:0] seq0[6]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`ifdef KEYSTREAM_ROTATE_EN
  logic [7:0] enc0[6]  = '{8'h11, 8'h23, 8'h31, 8'h47, 8'h26, 8'h41};
  logic [7:0] encEn[6] = '{8'h01, 8'h33, 8'h21, 8'h57, 8'h36, 8'h51};
`else
  logic [7:0] enc0[6]  = '{8'h11, 8'h23, 8'h31, 8'h47, 8'h15, 8'h27};
  logic [7:0] encEn[6] = '{8'h01, 8'h33, 8'h21, 8'h57, 8'h05, 8'h37};
`endif
  logic [7:0] bpIn[6]  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00};
  logic [7:0] bpExp[6] = '{8'hB1, 8'h83, 8'h91, 8'hE7, 8'h00, 8'h00};
  logic [7:0] enIn[6]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    // Reset state
    #1;
    chk("rst_data", oData, 0);
    chk("rst_vld", oData_Valid, 0);
    chk("rst_rdy", oData_Ready, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_kerr", oKey_Err, 0);
    #20 iRst = 1'b1; iEn = 1'b1;
    tick();

    // Start without a key
    startFrame(8'd5);
    chk("nokey_err", oKey_Err, 1);
    chk("nokey_busy", oBusy, 0);

    // Key load clears the error
    iKey = 32'h44332211; iKey_Load = 1'b1;
    tick();
    iKey_Load = 1'b0;
    chk("kload_err", oKey_Err, 0);

    // Basic frame and done timing
    runFrame("basic", seq0, enc0, 6);
    chk("done_lat", doneCyc - lastOutCyc, 1);
    // Second frame reproduces the same stream
    runFrame("again", seq0, enc0, 6);
    // Round trip
    runFrame("round", enc0, seq0, 6);

    // Backpressure
    bpMode = 1'b1;
    runFrame("bp", bpIn, bpExp, 4);
    bpMode = 1'b0;
    chk("bp_stalls", stallCnt > 0, 1);
    tick();

    // Zero-length frame
    d0 = doneCnt;
    outQ.delete();
    startFrame(8'd0);
    chk("len0_done", oDone, 1);
    tick();
    chk("len0_cnt", doneCnt, d0 + 1);
    chk("len0_out", outQ.size(), 0);
    chk("len0_busy", oBusy, 0);

    // Enable freeze mid-frame
    d0 = doneCnt;
    outQ.delete();
    startFrame(8'd6);
    sendWord(enIn[0]);
    sendWord(enIn[1]);
    iEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_data", oData, 8'h33);
      chk("frz_vld", oData_Valid, 1);
      chk("frz_rdy", oData_Ready, 0);
      chk("frz_busy", oBusy, 1);
      chk("frz_done", oDone, 0);
    end
    iEn = 1'b1;
    for (int i = 2; i < 6; i++) sendWord(enIn[i]);
    waitDone(d0);
    tick();
    chk("en_n", outQ.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < outQ.size()) chk("en", outQ[i], encEn[i]);

    // Reset mid-frame
    startFrame(8'd6);
    sendWord(8'h00);
    sendWord(8'h01);
    iRst = 1'b0;
    #1;
    chk("mrst_data", oData, 0);
    chk("mrst_vld", oData_Valid, 0);
    chk("mrst_busy", oBusy, 0);
    chk("mrst_rdy", oData_Ready, 0);
    chk("mrst_kerr", oKey_Err, 0);
    #10 iRst = 1'b1;
    tick();
    startFrame(8'd6);
    chk("mrst_nokey", oKey_Err, 1);
    chk("mrst_idle", oBusy, 0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
    $finish;
  end
endmodule
